// File: rtl/uart_echo_tester.sv
// rtl/uart_echo_tester.sv - UART echo loop initiator: send a pattern byte, await its echo, compare, count
// Define UART_ECHO_LFSR_EN to replace the incrementing pattern with an 8-bit LFSR (x^8+x^6+x^5+x^4+1).
module uart_echo_tester #(
  parameter int CLK_FREQ      = 65_000_000,
  parameter int BAUT_RATE     = 115200,
  parameter int TIMEOUT_BYTES = 4,
  parameter int GAP_CYCLES    = 16
) (
  input  logic        clk,
  input  logic        sys_rst_n,
  input  logic        start,
  output logic [7:0]  tx_data,
  output logic        tx_flag,
  input  logic        tx_done,
  input  logic [7:0]  rx_data,
  input  logic        rx_valid,
  output logic        busy,
  output logic [31:0] pass_cnt,
  output logic [15:0] err_cnt,
  output logic [15:0] timeout_cnt,
  output logic [7:0]  last_exp,
  output logic [7:0]  last_got
);

  localparam int          T_CYCLES = TIMEOUT_BYTES * 10 * (CLK_FREQ / BAUT_RATE);
  localparam logic [31:0] T_LAST   = (T_CYCLES > 0) ? 32'(T_CYCLES - 1) : 32'd0;
  localparam logic [31:0] GAP_LAST = (GAP_CYCLES > 0) ? 32'(GAP_CYCLES - 1) : 32'd0;
`ifdef UART_ECHO_LFSR_EN
  localparam logic [7:0]  PATTERN_SEED = 8'h01;
`else
  localparam logic [7:0]  PATTERN_SEED = 8'h00;
`endif

  typedef enum logic [1:0] {IDLE, SEND, WAIT_ECHO, GAP} state_t;

  state_t      state_q, state_d;
  logic [31:0] cnt_q, cnt_d;
  logic [7:0]  pattern_q, pattern_d;
  logic [7:0]  exp_q, exp_d;
  logic [7:0]  tx_data_q, tx_data_d;
  logic        tx_flag_q, tx_flag_d;
  logic [31:0] pass_q, pass_d;
  logic [15:0] err_q, err_d;
  logic [15:0] to_q, to_d;
  logic [7:0]  last_exp_q, last_exp_d;
  logic [7:0]  last_got_q, last_got_d;
  logic        rx_valid_q;

  logic rx_evt;
  logic timeout_hit;
  logic gap_done;

  function automatic logic [7:0] next_pattern(input logic [7:0] p);
`ifdef UART_ECHO_LFSR_EN
    return {p[6:0], p[7] ^ p[5] ^ p[4] ^ p[3]};
`else
    return p + 8'd1;
`endif
  endfunction

  function automatic logic [31:0] sat_inc32(input logic [31:0] v);
    return (v == '1) ? v : v + 32'd1;
  endfunction

  function automatic logic [15:0] sat_inc16(input logic [15:0] v);
    return (v == '1) ? v : v + 16'd1;
  endfunction

  assign rx_evt      = rx_valid & ~rx_valid_q;
  assign timeout_hit = (cnt_q == T_LAST);
  assign gap_done    = (cnt_q >= GAP_LAST);

  always_ff @(posedge clk or negedge sys_rst_n) begin
    if (!sys_rst_n) begin
      state_q <= IDLE;
    end else begin
      state_q <= state_d;
    end
  end

  always_comb begin
    state_d = state_q;
    case (state_q)
      IDLE:      if (start) state_d = SEND;
      SEND:      if (tx_done) state_d = WAIT_ECHO;
      WAIT_ECHO: if (rx_evt || timeout_hit) state_d = GAP;
      GAP:       if (gap_done) state_d = start ? SEND : IDLE;
      default:   state_d = IDLE;
    endcase
  end

  // An echo arriving on the expiry cycle is judged as an echo, never as a timeout.
  always_comb begin
    cnt_d      = cnt_q;
    pattern_d  = pattern_q;
    exp_d      = exp_q;
    tx_data_d  = tx_data_q;
    tx_flag_d  = 1'b0;
    pass_d     = pass_q;
    err_d      = err_q;
    to_d       = to_q;
    last_exp_d = last_exp_q;
    last_got_d = last_got_q;
    case (state_q)
      SEND: begin
        if (tx_done) begin
          tx_flag_d = 1'b1;
          tx_data_d = pattern_q;
          exp_d     = pattern_q;
          cnt_d     = '0;
        end
        if (rx_evt) err_d = sat_inc16(err_q);
      end
      WAIT_ECHO: begin
        cnt_d = cnt_q + 32'd1;
        if (rx_evt) begin
          if (rx_data == exp_q) begin
            pass_d = sat_inc32(pass_q);
          end else begin
            err_d      = sat_inc16(err_q);
            last_exp_d = exp_q;
            last_got_d = rx_data;
          end
          cnt_d     = '0;
          pattern_d = next_pattern(pattern_q);
        end else if (timeout_hit) begin
          to_d      = sat_inc16(to_q);
          cnt_d     = '0;
          pattern_d = next_pattern(pattern_q);
        end
      end
      GAP: begin
        cnt_d = cnt_q + 32'd1;
        if (rx_evt) err_d = sat_inc16(err_q);
      end
      default: begin
        if (rx_evt) err_d = sat_inc16(err_q);
      end
    endcase
  end

  always_ff @(posedge clk or negedge sys_rst_n) begin
    if (!sys_rst_n) begin
      cnt_q      <= '0;
      pattern_q  <= PATTERN_SEED;
      exp_q      <= '0;
      tx_data_q  <= '0;
      tx_flag_q  <= 1'b0;
      pass_q     <= '0;
      err_q      <= '0;
      to_q       <= '0;
      last_exp_q <= '0;
      last_got_q <= '0;
      rx_valid_q <= 1'b0;
    end else begin
      cnt_q      <= cnt_d;
      pattern_q  <= pattern_d;
      exp_q      <= exp_d;
      tx_data_q  <= tx_data_d;
      tx_flag_q  <= tx_flag_d;
      pass_q     <= pass_d;
      err_q      <= err_d;
      to_q       <= to_d;
      last_exp_q <= last_exp_d;
      last_got_q <= last_got_d;
      rx_valid_q <= rx_valid;
    end
  end

  assign busy        = (state_q != IDLE);
  assign tx_data     = tx_data_q;
  assign tx_flag     = tx_flag_q;
  assign pass_cnt    = pass_q;
  assign err_cnt     = err_q;
  assign timeout_cnt = to_q;
  assign last_exp    = last_exp_q;
  assign last_got    = last_got_q;

endmodule

// File: tb/tb_uart_echo_tester.sv
// tb/tb_uart_echo_tester.sv - self-checking bench for uart_echo_tester with a transaction-level echo model
module tb_uart_echo_tester;

  localparam int CLK_FREQ      = 50;
  localparam int BAUT_RATE     = 10;
  localparam int TIMEOUT_BYTES = 4;
  localparam int GAP_CYCLES    = 4;
  localparam int T             = TIMEOUT_BYTES * 10 * (CLK_FREQ / BAUT_RATE);
  localparam int G1            = (GAP_CYCLES > 0) ? GAP_CYCLES : 1;

  localparam int A_ECHO   = 0;
  localparam int A_CORR   = 1;
  localparam int A_DROP   = 2;
  localparam int A_EXPIRE = 3;

  logic        clk = 1'b0;
  logic        sys_rst_n;
  logic        start;
  logic [7:0]  tx_data;
  logic        tx_flag;
  logic        tx_done = 1'b1;
  logic [7:0]  rx_data;
  logic        rx_valid;
  logic        busy;
  logic [31:0] pass_cnt;
  logic [15:0] err_cnt;
  logic [15:0] timeout_cnt;
  logic [7:0]  last_exp;
  logic [7:0]  last_got;

  int n_cmp = 0;
  int n_bad = 0;

  always #5 clk = ~clk;

  uart_echo_tester #(
    .CLK_FREQ(CLK_FREQ), .BAUT_RATE(BAUT_RATE),
    .TIMEOUT_BYTES(TIMEOUT_BYTES), .GAP_CYCLES(GAP_CYCLES)
  ) dut (
    .clk(clk), .sys_rst_n(sys_rst_n), .start(start),
    .tx_data(tx_data), .tx_flag(tx_flag), .tx_done(tx_done),
    .rx_data(rx_data), .rx_valid(rx_valid), .busy(busy),
    .pass_cnt(pass_cnt), .err_cnt(err_cnt), .timeout_cnt(timeout_cnt),
    .last_exp(last_exp), .last_got(last_got)
  );

  // Transmitter model: goes busy for tx_busy_len cycles after each send request.
  int tx_busy_len = 50;
  int tx_left = 0;
  always @(negedge clk) begin
    if (!sys_rst_n) begin
      tx_done = 1'b1;
      tx_left = 0;
    end else if (tx_flag) begin
      tx_done = 1'b0;
      tx_left = tx_busy_len;
    end else if (tx_left > 0) begin
      tx_left = tx_left - 1;
      if (tx_left == 0) tx_done = 1'b1;
    end
  end

  logic [7:0] m_pat;
  int         m_pass, m_err, m_to;
  logic [7:0] m_le, m_lg;

  function automatic logic [7:0] next_pat(input logic [7:0] p);
`ifdef UART_ECHO_LFSR_EN
    return {p[6:0], ^(p & 8'hB8)};
`else
    return 8'((int'(p) + 1) % 256);
`endif
  endfunction

  task automatic model_reset();
`ifdef UART_ECHO_LFSR_EN
    m_pat = 8'h01;
`else
    m_pat = 8'h00;
`endif
    m_pass = 0; m_err = 0; m_to = 0; m_le = 8'h00; m_lg = 8'h00;
  endtask

  task automatic check(input string name, input logic [31:0] got, input logic [31:0] exp);
    n_cmp++;
    if (got !== exp) begin
      n_bad++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h at %0t", name, got, exp, $time);
    end
  endtask

  task automatic check_all();
    check("pass_cnt", pass_cnt, 32'(m_pass));
    check("err_cnt", 32'(err_cnt), 32'(m_err));
    check("timeout_cnt", 32'(timeout_cnt), 32'(m_to));
    check("last_exp", 32'(last_exp), 32'(m_le));
    check("last_got", 32'(last_got), 32'(m_lg));
  endtask

  task automatic check_zero();
    check("rst_tx_data", 32'(tx_data), 32'd0);
    check("rst_tx_flag", 32'(tx_flag), 32'd0);
    check("rst_busy", 32'(busy), 32'd0);
    check("rst_pass_cnt", pass_cnt, 32'd0);
    check("rst_err_cnt", 32'(err_cnt), 32'd0);
    check("rst_timeout_cnt", 32'(timeout_cnt), 32'd0);
    check("rst_last_exp", 32'(last_exp), 32'd0);
    check("rst_last_got", 32'(last_got), 32'd0);
  endtask

  task automatic wait_flag(output int n);
    n = 0;
    while (1) begin
      @(negedge clk);
      n++;
      if (tx_flag) return;
      if (n >= 1000) begin
        n_cmp++;
        n_bad++;
        $display("FAIL flag_wait: no tx_flag within %0d cycles at %0t", n, $time);
        n = -1;
        return;
      end
    end
  endtask

  // Called at the negedge of a tx_flag cycle; plays the far end for one byte.
  task automatic run_byte(input int act, input int d_in, input int h, input logic [7:0] x);
    logic [7:0] sent;
    int k, d;
    sent = tx_data;
    check("tx_data", 32'(tx_data), 32'(m_pat));
    k = 0;
    if (act == A_DROP) begin
      while (k < T - 1) begin @(negedge clk); k++; end
      check("timeout_early", 32'(timeout_cnt), 32'(m_to));
      check("busy_wait", 32'(busy), 32'd1);
      @(negedge clk);
      m_to++;
      m_pat = next_pat(m_pat);
      check_all();
    end else begin
      d = (act == A_EXPIRE) ? T - 1 : d_in;
      while (k < d) begin @(negedge clk); k++; end
      rx_data  = (act == A_CORR) ? (sent ^ x) : sent;
      rx_valid = 1'b1;
      @(negedge clk);
      if (h <= 1) rx_valid = 1'b0;
      if (rx_data == m_pat) begin
        m_pass++;
      end else begin
        m_err++;
        m_le = m_pat;
        m_lg = rx_data;
      end
      m_pat = next_pat(m_pat);
      check_all();
      if (h > 1) begin
        repeat (h - 1) @(negedge clk);
        rx_valid = 1'b0;
      end
    end
  endtask

  typedef struct {
    int         act;
    int         d;
    logic [7:0] exp_tx;
    int         exp_pass;
    int         exp_err;
    int         exp_to;
    logic [7:0] exp_le;
    logic [7:0] exp_lg;
    bit         chk_gap;
  } vec_t;

  vec_t       vec [8];
  logic [7:0] tp [8];

  initial begin
    #900_000;
    $display("FAIL global_timeout: bench did not finish at %0t", $time);
    $fatal(1);
  end

  initial begin
    int n, flags, r;
`ifdef UART_ECHO_LFSR_EN
    tp = '{8'h01, 8'h02, 8'h04, 8'h08, 8'h11, 8'h23, 8'h47, 8'h8E};
`else
    tp = '{8'h00, 8'h01, 8'h02, 8'h03, 8'h04, 8'h05, 8'h06, 8'h07};
`endif
    vec[0] = '{A_ECHO,   20, tp[0], 1, 0, 0, 8'h00, 8'h00,         1'b0};
    vec[1] = '{A_ECHO,    3, tp[1], 2, 0, 0, 8'h00, 8'h00,         1'b0};
    vec[2] = '{A_DROP,    0, tp[2], 2, 0, 1, 8'h00, 8'h00,         1'b1};
    vec[3] = '{A_ECHO,    1, tp[3], 3, 0, 1, 8'h00, 8'h00,         1'b0};
    vec[4] = '{A_CORR,   15, tp[4], 3, 1, 1, tp[4], tp[4] ^ 8'h80, 1'b0};
    vec[5] = '{A_ECHO,   30, tp[5], 4, 1, 1, tp[4], tp[4] ^ 8'h80, 1'b0};
    vec[6] = '{A_EXPIRE,  0, tp[6], 5, 1, 1, tp[4], tp[4] ^ 8'h80, 1'b1};
    vec[7] = '{A_ECHO,    8, tp[7], 6, 1, 1, tp[4], tp[4] ^ 8'h80, 1'b0};

    sys_rst_n = 1'b0; start = 1'b0; rx_valid = 1'b0; rx_data = 8'h00;
    repeat (3) @(negedge clk);
    check_zero();
    sys_rst_n = 1'b1;
    model_reset();
    @(negedge clk);

    start = 1'b1;
    wait_flag(n);
    check("start_latency", 32'(n), 32'd2);
    for (int i = 0; i < 8; i++) begin
      check("vec_tx", 32'(tx_data), 32'(vec[i].exp_tx));
      run_byte(vec[i].act, vec[i].d, 1, 8'h80);
      check("vec_pass", pass_cnt, 32'(vec[i].exp_pass));
      check("vec_err", 32'(err_cnt), 32'(vec[i].exp_err));
      check("vec_to", 32'(timeout_cnt), 32'(vec[i].exp_to));
      check("vec_last_exp", 32'(last_exp), 32'(vec[i].exp_le));
      check("vec_last_got", 32'(last_got), 32'(vec[i].exp_lg));
      if (i == 7) tx_busy_len = 20;
      wait_flag(n);
      if (vec[i].chk_gap) check("gap_to_flag", 32'(n), 32'(G1 + 1));
    end

    // Drop start mid-byte; the echo is still judged, held rx_valid counts once.
    start = 1'b0;
    run_byte(A_ECHO, 10, 5, 8'h00);
    check_all();
    flags = 0;
    repeat (20) begin
      @(negedge clk);
      if (tx_flag) flags++;
    end
    check("no_flag_after_stop", 32'(flags), 32'd0);
    check("busy_after_stop", 32'(busy), 32'd0);

    rx_data = 8'h5A; rx_valid = 1'b1;
    @(negedge clk);
    rx_valid = 1'b0;
    @(negedge clk);
    m_err++;
    check_all();
    check("busy_stray", 32'(busy), 32'd0);

    start = 1'b1;
    wait_flag(n);
    check("restart_latency", 32'(n), 32'd2);
    run_byte(A_ECHO, 5, 1, 8'h00);

    // Fresh run: ideal echoes with random timing.
    sys_rst_n = 1'b0; start = 1'b0;
    repeat (2) @(negedge clk);
    sys_rst_n = 1'b1;
    model_reset();
    @(negedge clk);
    start = 1'b1;
    for (int i = 0; i < 300; i++) begin
      tx_busy_len = $urandom_range(1, 60);
      wait_flag(n);
      if (n < 0) break;
      run_byte(A_ECHO, $urandom_range(1, 60), $urandom_range(1, 5), 8'h00);
    end
    check("ideal_pass_300", pass_cnt, 32'd300);
    check("ideal_err_0", 32'(err_cnt), 32'd0);
    check("ideal_to_0", 32'(timeout_cnt), 32'd0);

    // Random mix of faults against the model.
    for (int i = 0; i < 40; i++) begin
      tx_busy_len = $urandom_range(1, 60);
      wait_flag(n);
      if (n < 0) break;
      r = $urandom_range(0, 9);
      if (r == 0)      run_byte(A_DROP, 0, 1, 8'h00);
      else if (r == 1) run_byte(A_CORR, $urandom_range(1, 60), $urandom_range(1, 5), 8'($urandom_range(1, 255)));
      else if (r == 2) run_byte(A_EXPIRE, 0, 1, 8'h00);
      else             run_byte(A_ECHO, $urandom_range(1, 60), $urandom_range(1, 5), 8'h00);
    end

    wait_flag(n);
    repeat (5) @(negedge clk);
    sys_rst_n = 1'b0;
    #1;
    check_zero();

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
